pc_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the byte-addressed instruction memory.
//  - Holds the program counter and drives the memory address.
//  - Captures the combinational 32-bit big-endian instruction word into an IF/ID register.
//  - Presents that register to decode under a valid/ready handshake.
//  - Supports branch/jump redirect with flush, and halts on a misaligned redirect target.

---
 rtl/pc_fetch_unit.sv | 76 +++++++
 tb/tb_pc_fetch_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures the combinational imem word into
// an IF/ID register and hands it to decode, with redirect/flush and misalign halt.
module pc_fetch_unit #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              if_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              misalign_err,
  output logic [1:0]        fsm_state
);

  // Handshake: a word transfers to decode on a posedge where if_valid && if_ready;
  // while if_valid && !if_ready the IF/ID register and pc hold, and if_valid never
  // drops except on flush, halt or reset.

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

  state_t            state;
  logic [ADDR_W-1:0] pc;

  assign imem_addr = pc;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_PC_A;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= '0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            state        <= HALT;
            misalign_err <= 1'b1;
            if_valid     <= 1'b0;
          end else if (redirect_valid) begin
            pc       <= redirect_target;
            if_valid <= 1'b0;
          end else if (!if_valid || if_ready) begin
            if_instr <= imem_data;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc + PC_STEP;  // wraps modulo 2^ADDR_W by design
          end
        end
        HALT: if_valid <= 1'b0;
        default: begin
          state    <= HALT;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed table-driven bench for pc_fetch_unit with a big-endian byte memory model.
module tb_pc_fetch_unit;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_target = '0;
  logic              if_ready = 1'b0;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              misalign_err;
  logic [1:0]        fsm_state;

  logic [7:0] mem [0:2047];

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic              rst;
    logic              rv;
    logic [ADDR_W-1:0] rt;
    logic              rdy;
    logic              chk_data;
    logic              e_valid;
    logic [DATA_W-1:0] e_instr;
    logic [ADDR_W-1:0] e_pc;
    logic [ADDR_W-1:0] e_addr;
    logic              e_err;
    logic [1:0]        e_state;
  } vec_t;

  vec_t vecs[$];

  pc_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_ready        (if_ready),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .misalign_err    (misalign_err),
    .fsm_state       (fsm_state)
  );

  always #5 clk = ~clk;

  assign imem_data = {mem[imem_addr], mem[imem_addr + 11'd1],
                      mem[imem_addr + 11'd2], mem[imem_addr + 11'd3]};

  function automatic logic [31:0] word_at(input int a);
    if (a == 0) return 32'h0000_0013;
    if (a == 4) return 32'h0010_0093;
    return 32'hA500_0000 | 32'(a);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
  endtask

  task automatic add(input logic r, input logic rv, input int rt, input logic rdy,
                     input logic cd, input logic ev, input logic [31:0] ei,
                     input int epc, input int eaddr, input logic eerr,
                     input logic [1:0] est);
    vec_t v;
    v.rst = r; v.rv = rv; v.rt = ADDR_W'(rt); v.rdy = rdy; v.chk_data = cd;
    v.e_valid = ev; v.e_instr = ei; v.e_pc = ADDR_W'(epc); v.e_addr = ADDR_W'(eaddr);
    v.e_err = eerr; v.e_state = est;
    vecs.push_back(v);
  endtask

  initial begin
    int cycles;
    for (int a = 0; a < 2048; a += 4) begin
      logic [31:0] w;
      w = word_at(a);
      mem[a]   = w[31:24];
      mem[a+1] = w[23:16];
      mem[a+2] = w[15:8];
      mem[a+3] = w[7:0];
    end

    //   rst rv  rt     rdy cd ev instr              pc     addr   err st
    add(1, 0, 0,      1, 1, 0, 32'h0,             0,     0,     0, S_BOOT); // reset
    add(0, 0, 0,      1, 0, 0, 32'h0,             0,     0,     0, S_RUN);  // boot cycle
    add(0, 0, 0,      1, 1, 1, word_at(0),        0,     4,     0, S_RUN);
    add(0, 0, 0,      1, 1, 1, word_at(4),        4,     8,     0, S_RUN);
    add(0, 0, 0,      0, 1, 1, word_at(4),        4,     8,     0, S_RUN);  // stall x3
    add(0, 0, 0,      0, 1, 1, word_at(4),        4,     8,     0, S_RUN);
    add(0, 0, 0,      0, 1, 1, word_at(4),        4,     8,     0, S_RUN);
    add(0, 0, 0,      1, 1, 1, word_at(8),        8,     12,    0, S_RUN);  // release
    add(0, 1, 'h100,  0, 0, 0, 32'h0,             0,     'h100, 0, S_RUN);  // flush
    add(0, 0, 0,      0, 1, 1, word_at('h100),    'h100, 'h104, 0, S_RUN);
    add(0, 0, 0,      1, 1, 1, word_at('h104),    'h104, 'h108, 0, S_RUN);
    add(0, 1, 2040,   1, 0, 0, 32'h0,             0,     2040,  0, S_RUN);
    add(0, 0, 0,      1, 1, 1, word_at(2040),     2040,  2044,  0, S_RUN);
    add(0, 0, 0,      1, 1, 1, word_at(2044),     2044,  0,     0, S_RUN);  // wrap
    add(0, 0, 0,      1, 1, 1, word_at(0),        0,     4,     0, S_RUN);
    add(0, 1, 'h102,  1, 0, 0, 32'h0,             0,     4,     1, S_HALT); // misalign
    add(0, 1, 'h200,  1, 0, 0, 32'h0,             0,     4,     1, S_HALT);
    add(0, 0, 0,      1, 0, 0, 32'h0,             0,     4,     1, S_HALT);
    add(1, 0, 0,      1, 1, 0, 32'h0,             0,     0,     0, S_BOOT);
    add(0, 1, 'h300,  1, 0, 0, 32'h0,             0,     0,     0, S_RUN);  // boot ignores redirect
    add(0, 0, 0,      1, 1, 1, word_at(0),        0,     4,     0, S_RUN);
    add(0, 0, 0,      1, 1, 1, word_at(4),        4,     8,     0, S_RUN);
    add(0, 0, 0,      0, 1, 1, word_at(4),        4,     8,     0, S_RUN);
    add(1, 0, 0,      0, 1, 0, 32'h0,             0,     0,     0, S_BOOT); // reset mid-stall
    add(0, 0, 0,      1, 0, 0, 32'h0,             0,     0,     0, S_RUN);
    add(0, 0, 0,      1, 1, 1, word_at(0),        0,     4,     0, S_RUN);

    foreach (vecs[i]) begin
      rst             = vecs[i].rst;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].rt;
      if_ready        = vecs[i].rdy;
      @(posedge clk);
      #1;
      check("if_valid", i, 32'(if_valid), 32'(vecs[i].e_valid));
      check("imem_addr", i, 32'(imem_addr), 32'(vecs[i].e_addr));
      check("misalign_err", i, 32'(misalign_err), 32'(vecs[i].e_err));
      check("fsm_state", i, 32'(fsm_state), 32'(vecs[i].e_state));
      if (vecs[i].chk_data) begin
        check("if_instr", i, if_instr, vecs[i].e_instr);
        check("if_pc", i, 32'(if_pc), 32'(vecs[i].e_pc));
      end
    end

    // Reset wins over a same-cycle redirect, then first word arrives two cycles later.
    rst = 1'b1; redirect_valid = 1'b1; redirect_target = 11'h100; if_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_vs_redirect_addr", 100, 32'(imem_addr), 32'h0);
    check("rst_vs_redirect_state", 100, 32'(fsm_state), 32'(S_BOOT));
    rst = 1'b0; redirect_valid = 1'b0;
    cycles = 0;
    while (!if_valid && cycles < 8) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("first_fetch_latency", 101, 32'(cycles), 32'd2);
    check("first_fetch_instr", 101, if_instr, word_at(0));
    check("first_fetch_pc", 101, 32'(if_pc), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
